// File: rtl/csa_accum_ctrl.sv
// Carry-save accumulator: sums COUNT unsigned N-bit operands, resolving once at the end.
// Optional macro CSA_ACCUM_CTRL_ABORT_EN adds an abort input that discards a run in progress.
module csa_accum_ctrl #(
    parameter int N     = 4,
    parameter int COUNT = 10
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N-1:0]   in_data,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [N+7:0]   total_sum,
    output logic           sb_carry,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           busy
`ifdef CSA_ACCUM_CTRL_ABORT_EN
    ,
    input  logic           abort
`endif
);

    localparam int W  = N + 8;
    localparam int CW = $clog2(COUNT + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    sum_q, sum_d;
    logic [W-1:0]    carry_q, carry_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    total_q, total_d;
    logic            sbc_q, sbc_d;

    logic            abort_w;
    logic [W-1:0]    carry_sh, op, csa_s, csa_c, rip_s;
    logic            rip_co;

`ifdef CSA_ACCUM_CTRL_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // Carry is stored unweighted; its shifted form feeds both the CSA and the resolve.
    assign carry_sh = {carry_q[W-2:0], 1'b0};
    assign op       = {8'b0, in_data};
    assign csa_s    = sum_q ^ carry_sh ^ op;
    assign csa_c    = (sum_q & carry_sh) | (sum_q & op) | (carry_sh & op);

    always_comb begin
        logic rc;
        rip_s = '0;
        rc    = 1'b0;
        for (int i = 0; i < W; i++) begin
            rip_s[i] = sum_q[i] ^ carry_sh[i] ^ rc;
            rc       = (sum_q[i] & carry_sh[i]) | (sum_q[i] & rc) | (carry_sh[i] & rc);
        end
        rip_co = rc;
    end

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        total_d = total_q;
        sbc_d   = sbc_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sum_d   = '0;
                    carry_d = '0;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (abort_w) begin
                    sum_d   = '0;
                    carry_d = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (in_valid) begin
                    sum_d   = csa_s;
                    carry_d = csa_c;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CW'(COUNT - 1))
                        state_d = RESOLVE;
                end
            end
            RESOLVE: begin
                if (abort_w) begin
                    sum_d   = '0;
                    carry_d = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    total_d = rip_s;
                    sbc_d   = rip_co;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sum_q   <= '0;
            carry_q <= '0;
            cnt_q   <= '0;
            total_q <= '0;
            sbc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            total_q <= total_d;
            sbc_q   <= sbc_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign total_sum = total_q;
    assign sb_carry  = sbc_q;

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Bench for csa_accum_ctrl: directed scenarios plus randomized runs against an arithmetic model.
module tb_csa_accum_ctrl;

    localparam int N     = 4;
    localparam int COUNT = 10;
    localparam int W     = N + 8;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [N-1:0]   in_data = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   total_sum;
    logic           sb_carry;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic           busy;
`ifdef CSA_ACCUM_CTRL_ABORT_EN
    logic           abort = 1'b0;
`endif

    int vectors = 0;
    int miscompares = 0;

    csa_accum_ctrl #(.N(N), .COUNT(COUNT)) dut (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .total_sum(total_sum),
        .sb_carry(sb_carry), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy)
`ifdef CSA_ACCUM_CTRL_ABORT_EN
        , .abort(abort)
`endif
    );

    always #5 clk = ~clk;

    // Model phases: 0 idle, 1 collecting operands, 2 resolving, 3 result held.
    int m_ph = 0, m_acc = 0, m_cnt = 0, m_total = 0;
    bit m_init = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_ph <= 0; m_acc <= 0; m_cnt <= 0; m_total <= 0; m_init <= 1;
        end else begin
            case (m_ph)
                0: if (start) begin m_ph <= 1; m_acc <= 0; m_cnt <= 0; end
                1: begin
`ifdef CSA_ACCUM_CTRL_ABORT_EN
                    if (abort) begin m_ph <= 0; m_acc <= 0; m_cnt <= 0; end else
`endif
                    if (in_valid) begin
                        m_acc <= m_acc + int'(in_data);
                        m_cnt <= m_cnt + 1;
                        if (m_cnt + 1 == COUNT) m_ph <= 2;
                    end
                end
                2: begin
`ifdef CSA_ACCUM_CTRL_ABORT_EN
                    if (abort) begin m_ph <= 0; m_acc <= 0; m_cnt <= 0; end else
`endif
                    begin m_total <= m_acc; m_ph <= 3; end
                end
                default: if (out_ready) m_ph <= 0;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_init) begin
            chk("in_ready", 32'(in_ready), 32'(m_ph == 1));
            chk("out_valid", 32'(out_valid), 32'(m_ph == 3));
            chk("busy", 32'(busy), 32'(m_ph != 0));
            chk("total_sum", 32'(total_sum), 32'(m_total % (1 << W)));
            chk("sb_carry", 32'(sb_carry), 32'((m_total >> W) & 1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string nm);
        int g = 0;
        while (!out_valid && g < 20) begin tick(); g++; end
        if (!out_valid) begin
            vectors++; miscompares++;
            $display("FAIL %s: out_valid never rose within 20 cycles", nm);
        end
    endtask

    task automatic run_const(input logic [N-1:0] v);
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < COUNT; i++) begin in_valid = 1'b1; in_data = v; tick(); end
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tick();
        reset = 1'b0;
        chk("reset_total", 32'(total_sum), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);

        // Ten 0xF operands back to back; result appears two cycles after the last handshake.
        run_const(4'hF);
        chk("lat_t1_out_valid", 32'(out_valid), 32'h0);
        tick();
        chk("lat_t2_out_valid", 32'(out_valid), 32'h1);
        chk("sum150", 32'(total_sum), 32'h096);
        chk("sum150_carry", 32'(sb_carry), 32'h0);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // Operands 0..9 with bubbles between them.
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < COUNT; i++) begin
            in_valid = 1'b1; in_data = N'(i); tick();
            in_valid = 1'b0; tick();
        end
        wait_done("sum45");
        chk("sum45", 32'(total_sum), 32'h02D);
        chk("sum45_in_ready", 32'(in_ready), 32'h0);

        // Result must stay put while the consumer stalls; start/in_valid ignored.
        for (int i = 0; i < 5; i++) begin
            start = i[0]; in_valid = ~i[0]; in_data = 4'h7; tick();
            chk("stall_valid", 32'(out_valid), 32'h1);
            chk("stall_sum", 32'(total_sum), 32'h02D);
        end
        in_valid = 1'b0;
        start = 1'b1; out_ready = 1'b1; tick(); start = 1'b0; out_ready = 1'b0;
        chk("release_busy", 32'(busy), 32'h0);
        tick();
        chk("release_idle", 32'(busy), 32'h0);

        // Reset mid-run discards the partial sum and clears outputs.
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 6; i++) begin in_valid = 1'b1; in_data = 4'h7; tick(); end
        in_valid = 1'b0; reset = 1'b1; tick(); reset = 1'b0;
        chk("midrst_total", 32'(total_sum), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_ready", 32'(in_ready), 32'h0);
        run_const(4'h1);
        wait_done("sum10");
        chk("sum10", 32'(total_sum), 32'h00A);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

`ifdef CSA_ACCUM_CTRL_ABORT_EN
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 3; i++) begin in_valid = 1'b1; in_data = 4'h5; tick(); end
        in_valid = 1'b0; abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_keep", 32'(total_sum), 32'h00A);
        run_const(4'h2);
        wait_done("sum20");
        chk("sum20", 32'(total_sum), 32'h014);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
`endif

        // Randomized runs: gaps, stray starts, stalls and occasional resets.
        for (int r = 0; r < 25; r++) begin
            int g;
            for (int d = 0; d < int'($urandom_range(0, 3)); d++) tick();
            start = 1'b1; tick(); start = 1'b0;
            g = 0;
            while (m_ph == 1 && g < 200) begin
                in_valid = ($urandom % 3) != 0;
                in_data  = N'($urandom);
                start    = ($urandom % 5) == 0;
                reset    = ($urandom % 80) == 0;
`ifdef CSA_ACCUM_CTRL_ABORT_EN
                abort    = ($urandom % 60) == 0;
`endif
                tick();
                reset = 1'b0;
`ifdef CSA_ACCUM_CTRL_ABORT_EN
                abort = 1'b0;
`endif
                g++;
            end
            in_valid = 1'b0; start = 1'b0;
            if (m_ph != 0) begin
                wait_done("rand_done");
                for (int d = 0; d < int'($urandom_range(0, 3)); d++) begin
                    start = $urandom; in_valid = $urandom; tick();
                end
                start = 1'b0; in_valid = 1'b0;
                out_ready = 1'b1; tick(); out_ready = 1'b0;
            end
        end
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
